// File: rtl/enc_job_ctrl.sv
// APB-slave job controller for the shared ECC encoder: decodes the codeword width,
// MSB-aligns the payload, holds the encoder inputs for its latency and captures the result.
module enc_job_ctrl #(
   parameter int unsigned AMBA_WORD       = 32,
   parameter int unsigned AMBA_ADDR_WIDTH = 20,
   parameter int unsigned ENC_LATENCY     = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   input  logic                       PWRITE,
   input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   input  logic [AMBA_WORD-1:0]       PWDATA,
   output logic [AMBA_WORD-1:0]       PRDATA,
   output logic                       PREADY,
   output logic                       enc_small,
   output logic                       enc_medium,
   output logic                       enc_large,
   output logic [AMBA_WORD-1:0]       enc_data_in,
   input  logic [AMBA_WORD-1:0]       enc_out,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned WIDTH_W = 2;
   localparam int unsigned SEL_W   = 3;

   localparam logic [SEL_W-1:0] ADDR_CTRL   = 3'd0;
   localparam logic [SEL_W-1:0] ADDR_DATA   = 3'd1;
   localparam logic [SEL_W-1:0] ADDR_WIDTH  = 3'd2;
   localparam logic [SEL_W-1:0] ADDR_RESULT = 3'd3;
   localparam logic [SEL_W-1:0] ADDR_STATUS = 3'd4;

   localparam logic [WIDTH_W-1:0] W_SMALL  = 2'b00;
   localparam logic [WIDTH_W-1:0] W_MEDIUM = 2'b01;
   localparam logic [WIDTH_W-1:0] W_LARGE  = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LAUNCH  = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t               state;
   logic [AMBA_WORD-1:0] data_q;
   logic [AMBA_WORD-1:0] result_q;
   logic [WIDTH_W-1:0]   width_q;
   logic [CNT_W-1:0]     cnt;
   logic                 err;

   logic [SEL_W-1:0]     addr;
   logic                 xfer;
   logic                 wr_ok;
   logic                 start;
   logic [AMBA_WORD-1:0] pad;
   logic                 unused_paddr;

   assign addr         = PADDR[4:2];
   assign unused_paddr = ^{PADDR[AMBA_ADDR_WIDTH-1:5], PADDR[1:0]};

   // RESULT reads stall until the running job has written its codeword
   assign PREADY = !(PSEL && !PWRITE && (addr == ADDR_RESULT) && busy);
   assign xfer   = PSEL & PENABLE & PREADY;
   assign wr_ok  = xfer & PWRITE & ~busy;
   assign start  = wr_ok && (addr == ADDR_CTRL) && PWDATA[0];

   // MSB-align the payload for the selected codeword size
   always_comb begin
      pad = '0;
      case (width_q)
         W_SMALL:  pad = {data_q[3:0],  {(AMBA_WORD-4){1'b0}}};
         W_MEDIUM: pad = {data_q[10:0], {(AMBA_WORD-11){1'b0}}};
         W_LARGE:  pad = {data_q[25:0], {(AMBA_WORD-26){1'b0}}};
         default:  pad = '0;
      endcase
   end

   always_comb begin
      PRDATA = '0;
      if (PSEL && PENABLE) begin
         case (addr)
            ADDR_DATA:   PRDATA = data_q;
            ADDR_WIDTH:  PRDATA = AMBA_WORD'(width_q);
            ADDR_RESULT: PRDATA = result_q;
            ADDR_STATUS: PRDATA = AMBA_WORD'({err, done, busy});
            default:     PRDATA = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         data_q      <= '0;
         width_q     <= '0;
         result_q    <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         enc_small   <= 1'b0;
         enc_medium  <= 1'b0;
         enc_large   <= 1'b0;
         enc_data_in <= '0;
      end else begin
         if (wr_ok && (addr == ADDR_DATA))  data_q  <= PWDATA;
         if (wr_ok && (addr == ADDR_WIDTH)) width_q <= PWDATA[WIDTH_W-1:0];

         case (state)
            IDLE: begin
               if (start) begin
                  done <= 1'b1;
                  err  <= 1'b1;
                  if (width_q != 2'b11) begin
                     done        <= 1'b0;
                     err         <= 1'b0;
                     busy        <= 1'b1;
                     cnt         <= CNT_W'(ENC_LATENCY);
                     enc_small   <= (width_q == W_SMALL);
                     enc_medium  <= (width_q == W_MEDIUM);
                     enc_large   <= (width_q == W_LARGE);
                     enc_data_in <= pad;
                     state       <= LAUNCH;
                  end
               end
            end
            LAUNCH: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= CAPTURE;
            end
            CAPTURE: begin
               result_q    <= enc_out;
               busy        <= 1'b0;
               done        <= 1'b1;
               enc_small   <= 1'b0;
               enc_medium  <= 1'b0;
               enc_large   <= 1'b0;
               enc_data_in <= '0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/enc_job_ctrl.md
Name: enc_job_ctrl

Overview:
APB-slave job controller that sequences the shared ECC encoder datapath.
- Software programs DATA and CODEWORD_WIDTH, then writes START.
- The block decodes the width into one-hot Small/Medium/Large, MSB-aligns the payload, and holds the encoder inputs stable for the encoder latency.
- It captures the right-aligned codeword into RESULT and reports busy/done/err in STATUS.

Parameters:
AMBA_WORD, 32, data/codeword bus width
AMBA_ADDR_WIDTH, 20, APB address width
ENC_LATENCY, 1, clock cycles from encoder input valid to enc_out valid (1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write
PADDR  in  AMBA_ADDR_WIDTH  byte address; only PADDR[4:2] decoded
PWDATA  in  AMBA_WORD  write data
PRDATA  out  AMBA_WORD  read data
PREADY  out  1  APB ready
enc_small  out  1  encoder mode: 8-bit codeword
enc_medium  out  1  encoder mode: 16-bit codeword
enc_large  out  1  encoder mode: 32-bit codeword
enc_data_in  out  AMBA_WORD  padded payload to encoder
enc_out  in  AMBA_WORD  encoder result, right-aligned
busy  out  1  job in flight
done  out  1  sticky job-complete flag

Behaviour:
- Reset (async, rst=0): state IDLE; DATA, WIDTH, RESULT, counter = 0; busy = done = err = 0; all enc_* = 0; PRDATA = 0; PREADY = 1.
- Register map, PADDR[4:2]:
  - 0 CTRL: W; bit0 = START; reads 0.
  - 1 DATA: R/W.
  - 2 CODEWORD_WIDTH: R/W, bits[1:0]; 00 small, 01 medium, 10 large, 11 illegal.
  - 3 RESULT: RO.
  - 4 STATUS: RO; bit0 busy, bit1 done, bit2 err.
  - 5..7: reads 0, writes ignored.
- APB transfer is the cycle with PSEL & PENABLE & PREADY. PREADY = 1 except on a RESULT read while busy.
- Writes to DATA, WIDTH or CTRL while busy are dropped, with no error response.
- PRDATA is combinational from the addressed register during the access phase; 0 otherwise.
- FSM states: IDLE, LAUNCH, CAPTURE.
- IDLE:
  - START=1 with WIDTH≠11 accepted in cycle T: snapshot mode and padded data, clear done and err, go to LAUNCH at T+1.
  - START with WIDTH=11: no launch; set err=1 and done=1 at T+1; stay IDLE.
  - Payload padding:
    - small: {DATA[3:0], 28'b0}
    - medium: {DATA[10:0], 21'b0}
    - large: {DATA[25:0], 6'b0}
- LAUNCH: enc_data_in and exactly one mode bit driven from the snapshot, held stable. Down-counter loaded with ENC_LATENCY; go to CAPTURE after ENC_LATENCY cycles (T+1..T+ENC_LATENCY).
- CAPTURE (cycle T+ENC_LATENCY+1): RESULT <= enc_out. From T+ENC_LATENCY+2: done=1, busy=0, state IDLE, enc_* = 0.
- busy = 1 in LAUNCH and CAPTURE.
- A RESULT read stalled during a job completes (PREADY=1) in the first cycle busy=0, returning the new RESULT.
- START written in the same transfer as the job completing is dropped, since busy is still 1 in that cycle.
- done and err stay set until the next accepted START.
- Reset mid-job: immediate return to IDLE with all reset values; a pending stalled read is abandoned.

Test Plan:
- WIDTH=00, DATA=0x0000000B, START → enc_small=1 and enc_data_in=0xB0000000 at T+1; RESULT=0x000000B1; STATUS=0x2 at T+3 (ENC_LATENCY=1).
- WIDTH=10, DATA=0, START, with enc_out forced to 0xDEADBEEF → enc_large=1, enc_data_in=0; RESULT=0xDEADBEEF; busy high exactly 2 cycles.
- WIDTH=11, START → no enc_* assertion; STATUS=0x6 next cycle; RESULT unchanged.
- Read RESULT issued at T+1 of a job → PREADY=0 for 2 cycles, then PRDATA = new codeword; write DATA=0x5 during busy → DATA readback unchanged.
- ENC_LATENCY=3, medium job, DATA=0x7FF → enc_medium held 3 cycles, enc_data_in=0xFFE00000; done at T+5.
- rst pulled low in LAUNCH → all outputs 0 asynchronously, STATUS=0, next START runs normally.
